axi_d_merger: RTL and testbench

Downstream stage of axi_d_scheduler. It collects the scheduler's three AXI4-Stream master outputs and merges them into one AXI4-Stream.
- Arbitration is round-robin and packet-atomic: a granted input holds the output until its TLAST beat is accepted.
- Each output beat is tagged with its source index on TID.
- A 2-entry output FIFO removes any combinational path from M_AXIS_TREADY to S0i_AXIS_TREADY.

---
 rtl/axi_d_merger.sv | 199 +++++++++++++++++++
 tb/tb_axi_d_merger.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_d_merger.sv
// axi_d_merger: merges three AXI4-Stream inputs into one stream. Inputs are
// served round-robin and, in packet mode, one whole packet at a time. Each
// output beat carries its source index on TID. A 2-entry output FIFO keeps
// M_AXIS_TREADY off the combinational path to the input TREADYs.
//
// Valid/ready: a beat transfers on a rising edge where TVALID and TREADY are
// both high. A sender keeps TVALID, TDATA and TLAST stable until that edge.
// Every TREADY this block drives depends on registered state only.
module axi_d_merger #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_PACKET_MODE      = 1,
    parameter int C_PKT_CNT_WIDTH    = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] S00_AXIS_TDATA,
    input  logic                          S00_AXIS_TVALID,
    input  logic                          S00_AXIS_TLAST,
    output logic                          S00_AXIS_TREADY,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] S01_AXIS_TDATA,
    input  logic                          S01_AXIS_TVALID,
    input  logic                          S01_AXIS_TLAST,
    output logic                          S01_AXIS_TREADY,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] S02_AXIS_TDATA,
    input  logic                          S02_AXIS_TVALID,
    input  logic                          S02_AXIS_TLAST,
    output logic                          S02_AXIS_TREADY,
    output logic [C_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [1:0]                    M_AXIS_TID,
    output logic                          M_AXIS_TLAST,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic [C_PKT_CNT_WIDTH-1:0]    PKT_COUNT
);

    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int EW = DW + 3;  // FIFO entry: {tid, last, data}

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [1:0]           grant_q, grant_d;
    logic [1:0]           last_grant_q, last_grant_d;
    logic [1:0]           fifo_count_q, fifo_count_d;
    logic [EW-1:0]        head_q, head_d;
    logic [EW-1:0]        tail_q, tail_d;
    logic [C_PKT_CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

    logic [2:0]    in_valid;
    logic [DW-1:0] sel_data;
    logic          sel_valid;
    logic          sel_last;
    logic [1:0]    cand1, cand2, cand3, pick;
    logic          any_valid;
    logic          in_ready;
    logic          push;
    logic          pop;
    logic          m_valid;

    assign in_valid = {S02_AXIS_TVALID, S01_AXIS_TVALID, S00_AXIS_TVALID};

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Route the currently granted input onto the FIFO write side
    always_comb begin
        case (grant_q)
            2'd1: begin
                sel_data  = S01_AXIS_TDATA;
                sel_valid = S01_AXIS_TVALID;
                sel_last  = S01_AXIS_TLAST;
            end
            2'd2: begin
                sel_data  = S02_AXIS_TDATA;
                sel_valid = S02_AXIS_TVALID;
                sel_last  = S02_AXIS_TLAST;
            end
            default: begin
                sel_data  = S00_AXIS_TDATA;
                sel_valid = S00_AXIS_TVALID;
                sel_last  = S00_AXIS_TLAST;
            end
        endcase
    end

    // Round-robin search: first valid input after the one served last
    always_comb begin
        cand1     = rr_next(last_grant_q);
        cand2     = rr_next(cand1);
        cand3     = rr_next(cand2);
        any_valid = |in_valid;
        if (in_valid[cand1]) begin
            pick = cand1;
        end else if (in_valid[cand2]) begin
            pick = cand2;
        end else begin
            pick = cand3;
        end
    end

    assign m_valid  = (fifo_count_q != 2'd0);
    assign in_ready = (state_q == ST_BUSY) && (fifo_count_q < 2'd2);
    assign push     = in_ready && sel_valid;
    assign pop      = m_valid && M_AXIS_TREADY;

    // Arbiter state register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd2;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Arbiter next state: grant from IDLE, release on end of packet (or beat)
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d = ST_BUSY;
                    grant_d = pick;
                end
            end
            ST_BUSY: begin
                if (push && (sel_last || (C_PACKET_MODE == 0))) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter outputs: only the granted input sees TREADY, gated by FIFO room
    always_comb begin
        S00_AXIS_TREADY = in_ready && (grant_q == 2'd0);
        S01_AXIS_TREADY = in_ready && (grant_q == 2'd1);
        S02_AXIS_TREADY = in_ready && (grant_q == 2'd2);
    end

    // FIFO and packet counter next state; push with pop only happens at count 1
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        fifo_count_d = fifo_count_q;
        pkt_count_d  = pkt_count_q;
        case ({push, pop})
            2'b10: begin
                if (fifo_count_q == 2'd0) begin
                    head_d = {grant_q, sel_last, sel_data};
                end else begin
                    tail_d = {grant_q, sel_last, sel_data};
                end
                fifo_count_d = fifo_count_q + 2'd1;
            end
            2'b01: begin
                head_d       = tail_q;
                fifo_count_d = fifo_count_q - 2'd1;
            end
            2'b11: begin
                head_d = {grant_q, sel_last, sel_data};
            end
            default: ;
        endcase
        if (pop && head_q[DW]) begin
            pkt_count_d = pkt_count_q + C_PKT_CNT_WIDTH'(1);
        end
    end

    // FIFO storage and packet counter registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            head_q       <= '0;
            tail_q       <= '0;
            fifo_count_q <= 2'd0;
            pkt_count_q  <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            fifo_count_q <= fifo_count_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign M_AXIS_TDATA  = head_q[DW-1:0];
    assign M_AXIS_TLAST  = head_q[DW];
    assign M_AXIS_TID    = head_q[DW+2:DW+1];
    assign M_AXIS_TVALID = m_valid;
    assign PKT_COUNT     = pkt_count_q;

endmodule

// File: tb/tb_axi_d_merger.sv
// Bench for axi_d_merger: two instances (packet mode with a 16-bit counter,
// beat mode with a 4-bit counter), a queue-based behavioural model per
// instance checked every cycle, and directed sequences with literal results.
module tb_axi_d_merger;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst = 2'b11;
    logic [31:0] s_data [6];
    logic [5:0]  s_valid = '0;
    logic [5:0]  s_last = '0;
    wire  [5:0]  s_ready;
    wire  [31:0] m_data [2];
    wire  [1:0]  m_tid [2];
    wire  [1:0]  m_last;
    wire  [1:0]  m_valid;
    logic [1:0]  m_ready = '0;
    wire  [15:0] pkt0;
    wire  [3:0]  pkt1;

    axi_d_merger #(.C_AXIS_TDATA_WIDTH(32), .C_PACKET_MODE(1), .C_PKT_CNT_WIDTH(16)) dut0 (
        .ACLK(clk), .ARESET(rst[0]),
        .S00_AXIS_TDATA(s_data[0]), .S00_AXIS_TVALID(s_valid[0]), .S00_AXIS_TLAST(s_last[0]), .S00_AXIS_TREADY(s_ready[0]),
        .S01_AXIS_TDATA(s_data[1]), .S01_AXIS_TVALID(s_valid[1]), .S01_AXIS_TLAST(s_last[1]), .S01_AXIS_TREADY(s_ready[1]),
        .S02_AXIS_TDATA(s_data[2]), .S02_AXIS_TVALID(s_valid[2]), .S02_AXIS_TLAST(s_last[2]), .S02_AXIS_TREADY(s_ready[2]),
        .M_AXIS_TDATA(m_data[0]), .M_AXIS_TID(m_tid[0]), .M_AXIS_TLAST(m_last[0]),
        .M_AXIS_TVALID(m_valid[0]), .M_AXIS_TREADY(m_ready[0]), .PKT_COUNT(pkt0)
    );

    axi_d_merger #(.C_AXIS_TDATA_WIDTH(32), .C_PACKET_MODE(0), .C_PKT_CNT_WIDTH(4)) dut1 (
        .ACLK(clk), .ARESET(rst[1]),
        .S00_AXIS_TDATA(s_data[3]), .S00_AXIS_TVALID(s_valid[3]), .S00_AXIS_TLAST(s_last[3]), .S00_AXIS_TREADY(s_ready[3]),
        .S01_AXIS_TDATA(s_data[4]), .S01_AXIS_TVALID(s_valid[4]), .S01_AXIS_TLAST(s_last[4]), .S01_AXIS_TREADY(s_ready[4]),
        .S02_AXIS_TDATA(s_data[5]), .S02_AXIS_TVALID(s_valid[5]), .S02_AXIS_TLAST(s_last[5]), .S02_AXIS_TREADY(s_ready[5]),
        .M_AXIS_TDATA(m_data[1]), .M_AXIS_TID(m_tid[1]), .M_AXIS_TLAST(m_last[1]),
        .M_AXIS_TVALID(m_valid[1]), .M_AXIS_TREADY(m_ready[1]), .PKT_COUNT(pkt1)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int gap_pct = 0;
    int rdy_pct [2] = '{100, 100};
    logic [5:0]  acc = '0;
    logic [32:0] src_q [6][$];   // {last, data} beats waiting per source
    logic [34:0] log_q [2][$];   // observed output beats {tid, last, data}
    int          log_c [2][$];   // cycle of each observed output beat
    logic [34:0] exp_q [$];      // literal expectation for a directed sequence

    // behavioural model: output queue of depth 2, arbiter as plain integers
    logic [34:0] me [2][2];
    int          mcnt [2];
    bit          mbusy [2];
    int          mg [2];
    int          mlg [2];
    int          mpkt [2];
    bit          chk_en [2] = '{0, 0};

    task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0h expected %0h (t=%0t)", d, nm, act, exp, $time);
        end
    endtask

    function automatic logic [34:0] ent(input int tid, input bit last, input logic [31:0] data);
        logic [1:0] t;
        t = tid[1:0];
        return {t, last, data};
    endfunction

    // Model update on each rising edge, from the values seen before the edge
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit pop_m, push_m;
            int k;
            logic [34:0] e;
            if (m_valid[d] && m_ready[d]) begin
                log_q[d].push_back({m_tid[d], m_last[d], m_data[d]});
                log_c[d].push_back(cyc);
            end
            if (rst[d]) begin
                chk_en[d] = 1;
                mbusy[d]  = 0;
                mg[d]     = 0;
                mlg[d]    = 2;
                mcnt[d]   = 0;
                mpkt[d]   = 0;
                me[d][0]  = '0;
                me[d][1]  = '0;
                for (int i = 0; i < 3; i++) acc[d*3+i] = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) acc[d*3+i] = s_valid[d*3+i] && s_ready[d*3+i];
                k      = d*3 + mg[d];
                pop_m  = (mcnt[d] > 0) && m_ready[d];
                push_m = mbusy[d] && s_valid[k] && (mcnt[d] < 2);
                e      = ent(mg[d], s_last[k], s_data[k]);
                if (pop_m) begin
                    if (me[d][0][32]) mpkt[d] = (mpkt[d] + 1) & ((d == 0) ? 32'hFFFF : 32'hF);
                    me[d][0] = me[d][1];
                    mcnt[d]--;
                end
                if (push_m) begin
                    me[d][mcnt[d]] = e;
                    mcnt[d]++;
                end
                if (!mbusy[d]) begin
                    for (int j = 3; j >= 1; j--) begin
                        if (s_valid[d*3 + (mlg[d] + j) % 3]) begin
                            mg[d]    = (mlg[d] + j) % 3;
                            mbusy[d] = 1;
                        end
                    end
                end else if (push_m && (s_last[k] || d == 1)) begin
                    mbusy[d] = 0;
                    mlg[d]   = mg[d];
                end
            end
        end
        cyc++;
    end

    // Compare DUT outputs against the model in the middle of every cycle
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (chk_en[d]) begin
                chk(d, "m_tvalid", m_valid[d], (mcnt[d] != 0));
                if (mcnt[d] != 0) begin
                    chk(d, "m_tdata", m_data[d], me[d][0][31:0]);
                    chk(d, "m_tlast", m_last[d], me[d][0][32]);
                    chk(d, "m_tid", m_tid[d], me[d][0][34:33]);
                end
                for (int i = 0; i < 3; i++)
                    chk(d, "s_tready", s_ready[d*3+i], (mbusy[d] && mg[d] == i && mcnt[d] < 2));
                chk(d, "pkt_count", (d == 0) ? 64'(pkt0) : 64'(pkt1), mpkt[d]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if (acc[k] && s_valid[k]) begin
                if (src_q[k].size() > 0) src_q[k].delete(0);
                s_valid[k] = 1'b0;
            end
            if (!s_valid[k] && src_q[k].size() > 0 && $urandom_range(99) >= gap_pct) begin
                s_valid[k] = 1'b1;
                {s_last[k], s_data[k]} = src_q[k][0];
            end
        end
        for (int d = 0; d < 2; d++) m_ready[d] = ($urandom_range(99) < rdy_pct[d]);
    endtask

    task automatic load_pkt(input int k, input int len, input logic [31:0] base);
        for (int j = 0; j < len; j++) src_q[k].push_back({(j == len - 1), base + 32'(j)});
    endtask

    task automatic do_reset(input int d);
        for (int i = 0; i < 3; i++) begin
            src_q[d*3+i].delete();
            s_valid[d*3+i] = 1'b0;
        end
        rst[d] = 1'b1;
        step();
        rst[d] = 1'b0;
    endtask

    function automatic bit is_idle(input int d);
        bit r;
        r = (mcnt[d] == 0) && !mbusy[d];
        for (int i = 0; i < 3; i++) r = r && (src_q[d*3+i].size() == 0) && !s_valid[d*3+i];
        return r;
    endfunction

    task automatic drain(input int d);
        int n;
        n = 0;
        while (n < 2000 && !is_idle(d)) begin
            step();
            n++;
        end
        chk(d, "drain_done", (n < 2000), 1);
        repeat (2) step();
    endtask

    task automatic clear_log(input int d);
        log_q[d].delete();
        log_c[d].delete();
        exp_q.delete();
    endtask

    task automatic check_seq(input int d, input string tag);
        chk(d, {tag, " beats"}, log_q[d].size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < log_q[d].size(); j++)
            chk(d, {tag, " beat"}, log_q[d][j], exp_q[j]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        for (int k = 0; k < 6; k++) s_data[k] = '0;
        step();
        step();
        rst = 2'b00;
        step();
        // reset values
        chk(0, "reset m_tvalid", m_valid[0], 0);
        chk(0, "reset m_tdata", m_data[0], 0);
        chk(0, "reset m_tid", m_tid[0], 0);
        chk(0, "reset m_tlast", m_last[0], 0);
        chk(0, "reset pkt", pkt0, 0);
        chk(0, "reset s_tready", s_ready, 0);

        // single source, 8 beats
        clear_log(0);
        load_pkt(0, 8, 32'h01);
        for (int j = 0; j < 8; j++) exp_q.push_back(ent(0, j == 7, 32'(j + 1)));
        drain(0);
        check_seq(0, "single");
        chk(0, "single pkt", pkt0, 1);

        // three sources at once, 2 beats each
        do_reset(0);
        clear_log(0);
        for (int i = 0; i < 3; i++) begin
            load_pkt(i, 2, 32'(i * 16 + 1));
            exp_q.push_back(ent(i, 0, 32'(i * 16 + 1)));
            exp_q.push_back(ent(i, 1, 32'(i * 16 + 2)));
        end
        drain(0);
        check_seq(0, "three");
        chk(0, "three pkt", pkt0, 3);
        if (log_c[0].size() == 6) begin
            for (int j = 1; j < 6; j++) chk(0, "three spacing", log_c[0][j] - log_c[0][j-1], (j % 2 == 1) ? 1 : 2);
        end

        // fairness between inputs 0 and 2
        clear_log(0);
        for (int j = 0; j < 6; j++) begin
            load_pkt(0, 1, 32'hA0 + 32'(j));
            load_pkt(2, 1, 32'hC0 + 32'(j));
        end
        for (int j = 0; j < 6; j++) begin
            exp_q.push_back(ent(0, 1, 32'hA0 + 32'(j)));
            exp_q.push_back(ent(2, 1, 32'hC0 + 32'(j)));
        end
        drain(0);
        check_seq(0, "fair");

        // backpressure in the middle of an 8-beat packet
        clear_log(0);
        load_pkt(1, 8, 32'h100);
        for (int j = 0; j < 8; j++) exp_q.push_back(ent(1, j == 7, 32'h100 + 32'(j)));
        repeat (3) step();
        rdy_pct[0] = 0;
        repeat (5) step();
        chk(0, "stall s_tready", s_ready[1], 0);
        chk(0, "stall m_tvalid", m_valid[0], 1);
        rdy_pct[0] = 100;
        drain(0);
        check_seq(0, "bp");

        // reset after 3 of 8 beats
        load_pkt(0, 8, 32'h200);
        n = 0;
        while (src_q[0].size() > 5 && n < 50) begin
            step();
            n++;
        end
        chk(0, "partial accepted", src_q[0].size(), 5);
        do_reset(0);
        chk(0, "midrst m_tvalid", m_valid[0], 0);
        chk(0, "midrst pkt", pkt0, 0);
        chk(0, "midrst s_tready", s_ready[2:0], 0);
        clear_log(0);
        load_pkt(1, 2, 32'h300);
        exp_q.push_back(ent(1, 0, 32'h300));
        exp_q.push_back(ent(1, 1, 32'h301));
        drain(0);
        check_seq(0, "after rst");

        // beat mode: inputs 0 and 1 alternate per beat
        clear_log(1);
        load_pkt(3, 4, 32'h400);
        load_pkt(4, 4, 32'h410);
        for (int j = 0; j < 8; j++) exp_q.push_back(ent(j % 2, j >= 6, 32'h400 + 32'((j % 2) * 16 + j / 2)));
        drain(1);
        check_seq(1, "beatmode");
        chk(1, "beatmode pkt", pkt1, 2);

        // 4-bit packet counter wraps after 16
        do_reset(1);
        for (int j = 0; j < 17; j++) load_pkt(5, 1, 32'(j));
        drain(1);
        chk(1, "wrap pkt", pkt1, 1);

        // randomized traffic on both instances
        gap_pct = 25;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                for (int d = 0; d < 2; d++) begin
                    case ($urandom_range(2))
                        0: rdy_pct[d] = 100;
                        1: rdy_pct[d] = 60;
                        default: rdy_pct[d] = 25;
                    endcase
                end
            end
            for (int k = 0; k < 6; k++)
                if (src_q[k].size() < 4 && $urandom_range(99) < 15)
                    load_pkt(k, $urandom_range(1, 5), $urandom);
            if (c == 1500) do_reset(0);
            else step();
        end
        gap_pct = 0;
        rdy_pct[0] = 100;
        rdy_pct[1] = 100;
        drain(0);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
